// File: rtl/full_adder.sv
// full_adder: parameterisable ripple-carry adder (sum = a + b + cin)
// with zero-latency combinational results and a one-cycle registered copy.
//
// Ports:
//   clk       rising-edge clock for the registered stage
//   rst       asynchronous active-high reset for the registered stage
//   a, b      WIDTH-bit operands
//   cin       carry-in
//   in_valid  qualifies a/b/cin for capture by the registered stage
//   sum       combinational sum, (a+b+cin) mod 2^WIDTH
//   cout      combinational carry-out
//   ovf       combinational signed overflow (carry into MSB ^ cout)
//   prop      group propagate, AND of a[i]^b[i]
//   gen       group generate, carry-out with cin forced to 0
//   sum_q     registered sum (updated only when in_valid)
//   cout_q    registered cout (updated only when in_valid)
//   ovf_q     registered ovf (updated only when in_valid)
//   out_valid registered in_valid
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             prop,
  output logic             gen,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  // c: carry chain seeded with cin; g: parallel chain seeded with 0 for gen
  logic [WIDTH:0]   c;
  logic [WIDTH:0]   g;
  logic [WIDTH-1:0] p;

  assign c[0] = cin;
  assign g[0] = 1'b0;

  // One full-adder cell per bit, rippling carries from LSB to MSB
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign p[i]   = a[i] ^ b[i];
    assign sum[i] = p[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p[i]);
    assign g[i+1] = (a[i] & b[i]) | (g[i] & p[i]);
  end

  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH-1] ^ c[WIDTH];
  assign prop = &p;
  assign gen  = g[WIDTH];

  // Registered copy: results hold while in_valid is low, valid tracks every edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
        ovf_q  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed-vector bench for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  logic clk;
  logic rst;

  // WIDTH=1 instance signals
  logic a1, b1, cin1, iv1;
  logic sum1, cout1, ovf1, prop1, gen1, sumq1, coutq1, ovfq1, ov1;

  // WIDTH=8 instance signals
  logic [7:0] a8, b8, sum8, sumq8;
  logic       cin8, iv8, cout8, ovf8, prop8, gen8, coutq8, ovfq8, ov8;

  int nvec = 0;
  int nerr = 0;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .prop(prop1), .gen(gen1),
    .sum_q(sumq1), .cout_q(coutq1), .ovf_q(ovfq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .prop(prop8), .gen(gen8),
    .sum_q(sumq8), .cout_q(coutq8), .ovf_q(ovfq8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sweep table: {a,b,cin} and expected {sum,cout}
  logic [2:0] sw_in  [6] = '{3'b000, 3'b100, 3'b110, 3'b101, 3'b111, 3'b101};
  logic [1:0] sw_exp [6] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b01};

  initial begin
    logic [2:0]  v;
    logic [1:0]  e;
    logic [8:0]  e9;
    logic [7:0]  mq_sum;
    logic        mq_cout, mq_ovf, mq_v, exp_ovf;

    rst = 1'b1;
    {a1, b1, cin1, iv1} = 4'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;

    // Reset values, and combinational path live during reset
    #2;
    check("rst_sum_q",     32'(sumq1),  32'd0);
    check("rst_out_valid", 32'(ov1),    32'd0);
    check("rst_sum_q8",    32'(sumq8),  32'd0);
    check("rst_ov8",       32'(ov8),    32'd0);
    {a1, b1, cin1} = 3'b111;
    #1;
    check("comb_in_rst", 32'({sum1, cout1}), 32'b11);
    @(negedge clk);
    rst = 1'b0;

    // Combinational sweep, one step per 5 time units
    for (int i = 0; i < 6; i++) begin
      v = sw_in[i];
      e = sw_exp[i];
      {a1, b1, cin1} = v;
      #1;
      check("sweep", 32'({sum1, cout1}), 32'(e));
      #4;
    end

    // All eight single-bit combinations
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #1;
      check("tt_sum",  32'(sum1),  32'(v[2] ^ v[1] ^ v[0]));
      check("tt_cout", 32'(cout1), 32'((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])));
      check("tt_pg",   32'(cout1), 32'(gen1 | (prop1 & cin1)));
      check("tt_ovf",  32'(ovf1),  32'(v[0] ^ ((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]))));
    end

    // Registered stage: capture, then hold
    @(negedge clk);
    {a1, b1, cin1, iv1} = 4'b1101;
    @(posedge clk); #1;
    check("reg_sum_q",  32'(sumq1),  32'd0);
    check("reg_cout_q", 32'(coutq1), 32'd1);
    check("reg_ovf_q",  32'(ovfq1),  32'd1);
    check("reg_valid",  32'(ov1),    32'd1);
    @(negedge clk);
    a1 = 1'b0; iv1 = 1'b0;
    @(posedge clk); #1;
    check("hold_sum_q",  32'(sumq1),  32'd0);
    check("hold_cout_q", 32'(coutq1), 32'd1);
    check("hold_valid",  32'(ov1),    32'd0);

    // Mid-cycle asynchronous reset
    @(negedge clk);
    {a1, b1, cin1, iv1} = 4'b1001;
    @(posedge clk); #1;
    check("pre_rst_sum_q", 32'(sumq1), 32'd1);
    check("pre_rst_valid", 32'(ov1),   32'd1);
    #2;
    rst = 1'b1;
    {a1, b1, cin1} = 3'b011;
    #1;
    check("arst_sum_q",  32'(sumq1),  32'd0);
    check("arst_cout_q", 32'(coutq1), 32'd0);
    check("arst_ovf_q",  32'(ovfq1),  32'd0);
    check("arst_valid",  32'(ov1),    32'd0);
    check("arst_comb",   32'({sum1, cout1}), 32'b01);
    @(negedge clk);
    rst = 1'b0; iv1 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(ov1),   32'd0);
    check("post_rst_sum_q", 32'(sumq1), 32'd0);

    // WIDTH=8 directed boundaries
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    #1;
    check("w8_wrap_sum",  32'(sum8),  32'h00);
    check("w8_wrap_cout", 32'(cout8), 32'd1);
    check("w8_wrap_prop", 32'(prop8), 32'd1);
    check("w8_wrap_gen",  32'(gen8),  32'd0);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    #1;
    check("w8_ovf_sum",  32'(sum8),  32'h80);
    check("w8_ovf_cout", 32'(cout8), 32'd0);
    check("w8_ovf_ovf",  32'(ovf8),  32'd1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    check("w8_max", 32'({cout8, sum8}), 32'h1FF);

    // Random clocked operation against a reference model
    mq_sum = '0; mq_cout = 1'b0; mq_ovf = 1'b0; mq_v = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      iv8  = ($urandom_range(0, 3) != 0);
      #1;
      e9 = 9'(a8) + 9'(b8) + 9'(cin8);
      exp_ovf = (a8[7] == b8[7]) && (e9[7] != a8[7]);
      check("rnd_comb", 32'({cout8, sum8}), 32'(e9));
      check("rnd_ovf",  32'(ovf8), 32'(exp_ovf));
      @(posedge clk); #1;
      if (iv8) begin
        mq_sum = e9[7:0]; mq_cout = e9[8]; mq_ovf = exp_ovf;
      end
      mq_v = iv8;
      check("rnd_reg", 32'({ov8, ovfq8, coutq8, sumq8}),
            32'({mq_v, mq_ovf, mq_cout, mq_sum}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Ripple-carry full adder with single-bit default width: sum = a + b + cin, with carry-out.
- Provides combinational results for zero-latency use.
- Also provides a registered copy with a valid flag for pipelined datapaths.
- Leaf arithmetic cell used in adder and ALU datapaths.

Parameters:
- WIDTH, 1, operand width in bits (>= 1). WIDTH=1 is the classic single-bit full adder.

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst  input  1  asynchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- in_valid  input  1  qualifies a/b/cin for the registered stage
- sum  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH
- cout  output  1  combinational carry-out, bit WIDTH of a+b+cin
- ovf  output  1  combinational signed overflow, carry into MSB XOR cout
- prop  output  1  group propagate, AND of (a[i]^b[i])
- gen  output  1  group generate: cout computed with cin forced to 0
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered cout
- ovf_q  output  1  registered ovf
- out_valid  output  1  registered in_valid

Behaviour:
- Per-bit cell: s[i] = a[i]^b[i]^c[i]; c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])); c[0] = cin; cout = c[WIDTH].
- Built as an explicit ripple chain of WIDTH cells using generate, not a behavioural "+".
- Combinational outputs (sum, cout, ovf, prop, gen):
  - Purely combinational, no latency, settle in the same delta/time step as any input change.
  - Independent of clk and rst; valid even while rst is high.
- Single-bit truth table (WIDTH=1), written as a b cin -> sum cout:
  - 000->0 0, 001->1 0, 010->1 0, 011->0 1
  - 100->1 0, 101->0 1, 110->0 1, 111->1 1
- ovf: for WIDTH=1, ovf = c[0]^c[1] = cin^cout.
- prop: AND over i of (a[i]^b[i]).
- gen: carry-out of a+b with cin forced to 0.
- Identity: cout == gen | (prop & cin).
- Registered stage, at each rising clk edge:
  - When in_valid=1: sum_q<=sum, cout_q<=cout, ovf_q<=ovf.
  - When in_valid=0: sum_q, cout_q and ovf_q hold their previous values.
  - out_valid<=in_valid on every edge.
  - Latency is exactly 1 cycle.
- Reset:
  - rst high asynchronously clears sum_q=0, cout_q=0, ovf_q=0, out_valid=0, without waiting for a clock edge.
  - Registers hold these values while rst stays high.
  - First capture occurs on the first rising edge after rst deasserts.
  - Reset mid-stream discards any pending registered result.
- X handling: X/Z on any input propagates to the combinational outputs; no masking.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones, cout = 1. No saturation.

Test Plan:
- WIDTH=1, rst released, sweep a,b,cin through 000,100,110,101,111,101, one step per 5 time units, checking after inputs settle -> (sum,cout) = (0,0),(1,0),(0,1),(0,1),(1,1),(0,1).
- WIDTH=1, all 8 input combinations -> sum==a^b^cin, cout==majority(a,b,cin), cout==gen|(prop&cin) for every combination.
- WIDTH=1, in_valid=1, a=1 b=1 cin=0 -> one cycle later sum_q=0, cout_q=1, out_valid=1. Then in_valid=0 with a=0 -> sum_q and cout_q hold, out_valid=0.
- Assert rst between clock edges while sum_q=1 and out_valid=1 -> sum_q, cout_q, ovf_q and out_valid go to 0 immediately. Meanwhile combinational sum/cout still follow the inputs.
- WIDTH=8, a=0xFF b=0x00 cin=1 -> sum=0x00, cout=1, prop=1, gen=0. Then a=0x7F b=0x01 cin=0 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, 1000 random a/b/cin over continuous clocked operation -> {cout,sum}==a+b+cin every time, and registered outputs equal the previous cycle's combinational values.
